// File: rtl/param_password_checker.sv
// Password login FSM: ID latch, digit entry, ROM fetch with fixed latency, compare, session and hold-off.
// Optional lockout after forced logout is built when PWCHK_LOCKOUT_EN is defined.
module param_password_checker #(
  parameter int NUM_DIGITS  = 6,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int ID_W        = 3,
  parameter int ADDR_W      = 5,
  parameter int ROM_LAT     = 2,
  parameter int WAIT_CYC    = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid_i,
  input  logic [ID_W-1:0]               id_in_i,
  input  logic                          guest_in_i,
  input  logic [DIGIT_W-1:0]            digit_in_i,
  input  logic                          digit_stb_i,
  input  logic                          clear_stb_i,
  input  logic                          logout_req_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0]             rom_addr_o,
  output logic                          logged_in_o,
  output logic                          logged_out_o,
  output logic                          logout_pulse_o,
  output logic                          fail_pulse_o,
  output logic [2:0]                    tries_left_o,
  output logic [ID_W-1:0]               player_id_out_o,
  output logic                          guest_out_o,
  output logic                          locked_o
);
  localparam int PW_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = 4;
  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_FETCH, S_ROM_WAIT, S_COMPARE, S_SESSION, S_WAIT, S_LOCKOUT
  } state_e;

  state_e             state_q, state_d;
  logic [PW_W-1:0]    entry_q, rom_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [2:0]         tries_q;
  logic [ID_W-1:0]    id_q, pid_q;
  logic               guest_q, pguest_q;
  logic               mismatch, last_digit;

  assign mismatch   = (entry_q != rom_q);
  assign last_digit = digit_stb_i && !clear_stb_i && (cnt_q == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (id_valid_i) state_d = S_ENTRY;
      S_ENTRY:    if (last_digit) state_d = S_FETCH;
      S_FETCH:    state_d = S_ROM_WAIT;
      S_ROM_WAIT: if (tmr_q == TMR_W'(ROM_LAT - 1)) state_d = S_COMPARE;
      S_COMPARE: begin
        if (!mismatch)         state_d = S_SESSION;
        else if (tries_q != 3'd1) state_d = S_ENTRY;
        else begin
`ifdef PWCHK_LOCKOUT_EN
          state_d = S_LOCKOUT;
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_SESSION:  if (logout_req_i) state_d = S_WAIT;
      S_WAIT:     if (tmr_q == TMR_W'(WAIT_CYC - 1)) state_d = S_IDLE;
`ifdef PWCHK_LOCKOUT_EN
      S_LOCKOUT:  if (tmr_q == TMR_W'(LOCKOUT_CYC - 1)) state_d = S_WAIT;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath; the shared timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q  <= '0;
      rom_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      tries_q  <= '0;
      id_q     <= '0;
      guest_q  <= 1'b0;
      pid_q    <= '0;
      pguest_q <= 1'b0;
    end else begin
      tmr_q <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
      case (state_q)
        S_IDLE: if (id_valid_i) begin
          id_q    <= id_in_i;
          guest_q <= guest_in_i;
          cnt_q   <= '0;
          entry_q <= '0;
          tries_q <= 3'(MAX_TRIES);
        end
        S_ENTRY: begin
          if (clear_stb_i) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end else if (digit_stb_i) begin
            entry_q <= {entry_q[PW_W-DIGIT_W-1:0], digit_in_i};
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_ROM_WAIT: if (state_d == S_COMPARE) rom_q <= rom_data_i;
        S_COMPARE: begin
          entry_q <= '0;
          rom_q   <= '0;
          cnt_q   <= '0;
          if (mismatch) tries_q <= tries_q - 1'b1;
          else begin
            pid_q    <= id_q;
            pguest_q <= guest_q;
          end
        end
        S_SESSION: if (logout_req_i) begin
          entry_q  <= '0;
          pid_q    <= '0;
          pguest_q <= 1'b0;
        end
        S_FETCH, S_WAIT: ;
`ifdef PWCHK_LOCKOUT_EN
        S_LOCKOUT: ;
`endif
        default: begin
          entry_q  <= '0;
          rom_q    <= '0;
          cnt_q    <= '0;
          tries_q  <= '0;
          pid_q    <= '0;
          pguest_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rom_addr_o      = '0;
    logged_in_o     = 1'b0;
    logged_out_o    = 1'b1;
    logout_pulse_o  = 1'b0;
    fail_pulse_o    = 1'b0;
    tries_left_o    = tries_q;
    player_id_out_o = '0;
    guest_out_o     = 1'b0;
    locked_o        = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY, S_ROM_WAIT, S_WAIT: ;
      S_FETCH:   rom_addr_o = ADDR_W'(id_q);
      S_COMPARE: begin
        fail_pulse_o   = mismatch;
        logout_pulse_o = mismatch && (tries_q == 3'd1);
      end
      S_SESSION: begin
        logged_in_o     = 1'b1;
        logged_out_o    = 1'b0;
        logout_pulse_o  = logout_req_i;
        player_id_out_o = pid_q;
        guest_out_o     = pguest_q;
      end
`ifdef PWCHK_LOCKOUT_EN
      S_LOCKOUT: locked_o = 1'b1;
`endif
      default:   tries_left_o = '0;
    endcase
  end
endmodule
